// File: rtl/rx_byte_deframer.sv
// rtl/rx_byte_deframer.sv - COMMA lock, SOF/EOF frame extraction and 8-deep payload FIFO
module rx_byte_deframer #(
    parameter int          LOCK_COUNT = 4,
    parameter int          LOSS_COUNT = 8,
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter logic [7:0]  SOF        = 8'hFB,
    parameter logic [7:0]  EOF        = 8'hFD
) (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    input  logic       ready_in,
    output logic [7:0] data_out,
    output logic       last_out,
    output logic       valid_out,
    output logic       locked,
    output logic       frame_err,
    output logic       overflow,
    output logic [3:0] fifo_count
);

    localparam logic [3:0] LOCK_N = LOCK_COUNT[3:0];
    localparam logic [3:0] LOSS_N = LOSS_COUNT[3:0];

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        IN_FRAME = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  comma_cnt, comma_nxt;
    logic [3:0]  loss_cnt, loss_nxt;
    logic [7:0]  hold, hold_nxt;
    logic        hold_valid, hold_valid_nxt;
    logic        push;
    logic [8:0]  push_word;
    logic        err_nxt;

    logic [8:0]  mem [8];
    logic [2:0]  wr_ptr, rd_ptr;
    logic [3:0]  count;
    logic        full, pop, push_ok;

    always_ff @(posedge clk_2f) begin
        if (!reset) state <= UNLOCKED;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        comma_nxt      = comma_cnt;
        loss_nxt       = loss_cnt;
        hold_nxt       = hold;
        hold_valid_nxt = hold_valid;
        push           = 1'b0;
        push_word      = 9'd0;
        err_nxt        = 1'b0;
        if (valid_in) begin
            loss_nxt = 4'd0;
            case (state)
                UNLOCKED: begin
                    if (data_in == COMMA) begin
                        if (comma_cnt + 4'd1 == LOCK_N) begin
                            state_nxt = LOCKED;
                            comma_nxt = 4'd0;
                        end else begin
                            comma_nxt = comma_cnt + 4'd1;
                        end
                    end else begin
                        comma_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (data_in == SOF) begin
                        state_nxt      = IN_FRAME;
                        hold_valid_nxt = 1'b0;
                    end else if (data_in != COMMA) begin
                        err_nxt = 1'b1;
                    end
                end
                IN_FRAME: begin
                    if (data_in == SOF) begin
                        err_nxt        = 1'b1;
                        hold_valid_nxt = 1'b0;
                    end else if (data_in == EOF) begin
                        state_nxt      = LOCKED;
                        hold_valid_nxt = 1'b0;
                        if (hold_valid) begin
                            push      = 1'b1;
                            push_word = {1'b1, hold};
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (data_in != COMMA) begin
                        // One-byte lag lets EOF tag the final byte as last
                        if (hold_valid) begin
                            push      = 1'b1;
                            push_word = {1'b0, hold};
                        end
                        hold_nxt       = data_in;
                        hold_valid_nxt = 1'b1;
                    end
                end
                default: state_nxt = UNLOCKED;
            endcase
        end else if (state != UNLOCKED) begin
            if (loss_cnt + 4'd1 == LOSS_N) begin
                state_nxt      = UNLOCKED;
                loss_nxt       = 4'd0;
                comma_nxt      = 4'd0;
                hold_valid_nxt = 1'b0;
                err_nxt        = (state == IN_FRAME);
            end else begin
                loss_nxt = loss_cnt + 4'd1;
            end
        end
    end

    assign full    = (count == 4'd8);
    assign pop     = valid_out && ready_in;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            comma_cnt  <= 4'd0;
            loss_cnt   <= 4'd0;
            hold       <= 8'd0;
            hold_valid <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= 3'd0;
            rd_ptr     <= 3'd0;
            count      <= 4'd0;
            for (int i = 0; i < 8; i++) mem[i] <= 9'd0;
        end else begin
            comma_cnt  <= comma_nxt;
            loss_cnt   <= loss_nxt;
            hold       <= hold_nxt;
            hold_valid <= hold_valid_nxt;
            frame_err  <= err_nxt;
            if (push && !push_ok) overflow <= 1'b1;
            if (push_ok) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + 3'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 3'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    assign data_out   = mem[rd_ptr][7:0];
    assign last_out   = mem[rd_ptr][8];
    assign valid_out  = (count != 4'd0);
    assign fifo_count = count;
    assign locked     = (state != UNLOCKED);

endmodule

// File: tb/tb_rx_byte_deframer.sv
// tb/tb_rx_byte_deframer.sv - directed self-checking bench for rx_byte_deframer
module tb_rx_byte_deframer;

    logic       clk_2f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_in;
    logic [7:0] data_out;
    logic       last_out;
    logic       valid_out;
    logic       locked;
    logic       frame_err;
    logic       overflow;
    logic [3:0] fifo_count;

    int n_assert = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    logic [8:0] q [$];

    rx_byte_deframer dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .data_out   (data_out),
        .last_out   (last_out),
        .valid_out  (valid_out),
        .locked     (locked),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk_2f = ~clk_2f;

    always @(posedge clk_2f) begin
        if (reset && valid_out && ready_in) q.push_back({last_out, data_out});
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        data_in  = b;
        valid_in = 1'b1;
        @(posedge clk_2f);
        #1;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        @(posedge clk_2f);
        #1;
    endtask

    function automatic logic [8:0] qat(input int i);
        return (i < q.size()) ? q[i] : 9'h1FF;
    endfunction

    initial begin
        reset    = 1'b0;
        data_in  = 8'h00;
        valid_in = 1'b0;
        ready_in = 1'b0;
        repeat (2) @(posedge clk_2f);
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_count", fifo_count, 0);
        check("rst_locked", locked, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_data_last", {last_out, data_out}, 0);
        reset = 1'b1;

        // 1: lock acquisition, interrupted run restarts the count
        repeat (3) send(8'hBC);
        check("t1_after3", locked, 0);
        send(8'h11);
        repeat (3) send(8'hBC);
        check("t1_after3b", locked, 0);
        send(8'hBC);
        check("t1_locked", locked, 1);

        // 2: simple frame with idle COMMA inside, streamed out
        ready_in = 1'b1;
        send(8'hFB); send(8'hA1); send(8'hA2); send(8'hBC); send(8'hA3); send(8'hFD);
        repeat (3) send(8'hBC);
        check("t2_qsize", q.size(), 3);
        check("t2_b0", qat(0), 9'h0A1);
        check("t2_b1", qat(1), 9'h0A2);
        check("t2_b2", qat(2), 9'h1A3);
        check("t2_err", err_cnt, 0);
        check("t2_count", fifo_count, 0);

        // 3: overflow with consumer stalled
        q.delete();
        ready_in = 1'b0;
        send(8'hFB);
        for (int i = 0; i < 10; i++) send(8'h30 + 8'(i));
        send(8'hFD);
        check("t3_count", fifo_count, 8);
        check("t3_overflow", overflow, 1);
        check("t3_head", {last_out, data_out}, 9'h030);
        ready_in = 1'b1;
        repeat (8) send(8'hBC);
        check("t3_qsize", q.size(), 8);
        for (int i = 0; i < 8; i++) check("t3_byte", qat(i), {1'b0, 8'h30 + 8'(i)});
        check("t3_count_end", fifo_count, 0);
        check("t3_overflow_sticky", overflow, 1);

        // 4: SOF abort inside a frame
        q.delete();
        err_cnt = 0;
        send(8'hFB); send(8'h01); send(8'hFB);
        check("t4_err_pulse", frame_err, 1);
        send(8'h02);
        check("t4_err_low", frame_err, 0);
        send(8'hFD);
        repeat (2) send(8'hBC);
        check("t4_qsize", q.size(), 1);
        check("t4_b0", qat(0), 9'h102);
        check("t4_err_cnt", err_cnt, 1);

        // 5: loss of lock mid-frame
        q.delete();
        err_cnt = 0;
        send(8'hFB); send(8'h55);
        repeat (7) idle();
        check("t5_still_locked", locked, 1);
        check("t5_no_err_yet", frame_err, 0);
        idle();
        check("t5_unlocked", locked, 0);
        check("t5_err", frame_err, 1);
        check("t5_count", fifo_count, 0);
        idle();
        check("t5_err_one_cycle", frame_err, 0);
        check("t5_qsize", q.size(), 0);
        check("t5_err_cnt", err_cnt, 1);

        // 6: reset mid-frame
        repeat (4) send(8'hBC);
        check("t6_relocked", locked, 1);
        ready_in = 1'b0;
        send(8'hFB); send(8'h61); send(8'h62); send(8'h63); send(8'h64);
        check("t6_count3", fifo_count, 3);
        check("t6_head", {last_out, data_out}, 9'h061);
        reset = 1'b0;
        @(posedge clk_2f);
        #1;
        check("t6_valid_out", valid_out, 0);
        check("t6_count0", fifo_count, 0);
        check("t6_locked", locked, 0);
        check("t6_overflow", overflow, 0);
        check("t6_frame_err", frame_err, 0);
        reset = 1'b1;
        valid_in = 1'b0;
        repeat (2) @(posedge clk_2f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
